// File: rtl/tile_bg_renderer.sv
// ============================================================================
// Module   : tile_bg_renderer
// Purpose  : Pipelined background renderer. Scales a 2^IMG_W_LOG2 x
//            2^IMG_H_LOG2 palette-indexed bitmap up to the VGA raster with
//            shift-based scaling, wrap-around scrolling, an external ROM of
//            configurable read latency and a runtime-writable palette.
// Ports    : vga_clk, Reset (sync, active-high)
//            DrawX, DrawY, blank       raster position / active-video flag
//            scroll_x, scroll_y        texel scroll offsets (latched per frame)
//            rom_address, rom_q        external texel ROM interface
//            pal_we, pal_idx, pal_data palette write port ({R,G,B} 4b each)
//            fade_go, fade_dir         per-frame fade step (BG_FADE_EN only)
//            red, green, blue, opaque  registered pixel output
// Config   : define BG_FADE_EN to enable the per-frame brightness fade.
// Latency  : DrawX/DrawY/blank sample to colour output = ROM_LAT + 2 cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_bg_renderer #(
    parameter int IMG_W_LOG2  = 6,
    parameter int IMG_H_LOG2  = 6,
    parameter int SCALE_SHIFT = 3,
    parameter int IDX_W       = 4,
    parameter int ROM_LAT     = 1,
    parameter int TRANS_IDX   = 0
) (
    input  logic                             vga_clk,
    input  logic                             Reset,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    input  logic                             blank,
    input  logic [IMG_W_LOG2-1:0]            scroll_x,
    input  logic [IMG_H_LOG2-1:0]            scroll_y,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] rom_address,
    input  logic [IDX_W-1:0]                 rom_q,
    input  logic                             pal_we,
    input  logic [IDX_W-1:0]                 pal_idx,
    input  logic [11:0]                      pal_data,
    input  logic                             fade_go,
    input  logic                             fade_dir,
    output logic [3:0]                       red,
    output logic [3:0]                       green,
    output logic [3:0]                       blue,
    output logic                             opaque
);

    // Address stage, ROM_LAT ROM cycles, index register, palette/output stage.
    localparam int             c_PIPE      = ROM_LAT + 2;
    localparam int             c_PAL_DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] c_TRANS   = IDX_W'(TRANS_IDX);

    // ------------------------------------------------------------------
    // Address stage
    // ------------------------------------------------------------------
    logic [IMG_W_LOG2-1:0] r_scroll_x;
    logic [IMG_H_LOG2-1:0] r_scroll_y;
    logic                  w_frame_start;
    logic [IMG_W_LOG2-1:0] w_scroll_x;
    logic [IMG_H_LOG2-1:0] w_scroll_y;
    logic [9:0]            w_col;
    logic [9:0]            w_row;
    logic [IMG_W_LOG2-1:0] w_sx;
    logic [IMG_H_LOG2-1:0] w_sy;

    assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

    // Pixel (0,0) must already see the newly requested scroll, so bypass
    // the latch on the frame-start cycle.
    assign w_scroll_x = w_frame_start ? scroll_x : r_scroll_x;
    assign w_scroll_y = w_frame_start ? scroll_y : r_scroll_y;

    assign w_col = DrawX >> SCALE_SHIFT;
    assign w_row = DrawY >> SCALE_SHIFT;

    // Truncation to the texel width gives the wrap-around for free.
    assign w_sx = w_col[IMG_W_LOG2-1:0] + w_scroll_x;
    assign w_sy = w_row[IMG_H_LOG2-1:0] + w_scroll_y;

    logic w_unused_coord;
    assign w_unused_coord = &{1'b0, w_col, w_row};

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_scroll_x  <= '0;
            r_scroll_y  <= '0;
            rom_address <= '0;
        end else begin
            if (w_frame_start) begin
                r_scroll_x <= scroll_x;
                r_scroll_y <= scroll_y;
            end
            rom_address <= {w_sy, w_sx};
        end
    end

    // ------------------------------------------------------------------
    // blank delay line, aligned with the colour path
    // ------------------------------------------------------------------
    logic [c_PIPE-1:0] r_blank_sr;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_blank_sr <= '0;
        end else begin
            r_blank_sr <= {r_blank_sr[c_PIPE-2:0], blank};
        end
    end

    // ------------------------------------------------------------------
    // Index register and palette
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_idx;
    logic [11:0]      r_pal [c_PAL_DEPTH];
    logic [11:0]      w_entry;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_idx <= '0;
        end else begin
            r_idx <= rom_q;
        end
    end

    // A write and a lookup in the same cycle: the lookup reads the array
    // before the edge, so it returns the old entry.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            for (int i = 0; i < c_PAL_DEPTH; i++) begin
                r_pal[i] <= '0;
            end
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_data;
        end
    end

    assign w_entry = r_pal[r_idx];

    // ------------------------------------------------------------------
    // Optional fade
    // ------------------------------------------------------------------
    logic [3:0] w_red;
    logic [3:0] w_green;
    logic [3:0] w_blue;

`ifdef BG_FADE_EN
    logic [4:0] r_level;
    logic [7:0] w_prod_r;
    logic [7:0] w_prod_g;
    logic [7:0] w_prod_b;

    // (c * L) >> 4 with L in 0..16; the product never exceeds 240.
    assign w_prod_r = {4'd0, w_entry[11:8]} * {3'd0, r_level};
    assign w_prod_g = {4'd0, w_entry[7:4]}  * {3'd0, r_level};
    assign w_prod_b = {4'd0, w_entry[3:0]}  * {3'd0, r_level};
    assign w_red    = w_prod_r[7:4];
    assign w_green  = w_prod_g[7:4];
    assign w_blue   = w_prod_b[7:4];

    logic w_unused_fade;
    assign w_unused_fade = &{1'b0, w_prod_r[3:0], w_prod_g[3:0], w_prod_b[3:0]};

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_level <= 5'd16;
        end else if (w_frame_start && fade_go) begin
            if (fade_dir && (r_level != 5'd16)) begin
                r_level <= r_level + 5'd1;
            end else if (!fade_dir && (r_level != 5'd0)) begin
                r_level <= r_level - 5'd1;
            end
        end
    end
`else
    assign w_red   = w_entry[11:8];
    assign w_green = w_entry[7:4];
    assign w_blue  = w_entry[3:0];

    logic w_unused_fade;
    assign w_unused_fade = &{1'b0, fade_go, fade_dir};
`endif

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (Reset || !r_blank_sr[c_PIPE-1]) begin
            red    <= 4'd0;
            green  <= 4'd0;
            blue   <= 4'd0;
            opaque <= 1'b0;
        end else begin
            red    <= w_red;
            green  <= w_green;
            blue   <= w_blue;
            opaque <= (r_idx != c_TRANS);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tile_bg_renderer.sv
// ============================================================================
// Module   : tb_tile_bg_renderer
// Purpose  : Self-checking bench for tile_bg_renderer. Two instances
//            (ROM_LAT=1 and ROM_LAT=3) share stimulus; each has its own
//            latency-accurate ROM. A sample-history model predicts addresses
//            and pixels every cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_bg_renderer;

    localparam int c_HIST = 16384;

    logic        vga_clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [5:0]  scroll_x, scroll_y;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_data;
    logic        fade_go, fade_dir;

    logic [11:0] rom_address1, rom_address3;
    logic [3:0]  rom_q1 = 4'd0, rom_q3 = 4'd0;
    logic [3:0]  red1, green1, blue1, red3, green3, blue3;
    logic        opaque1, opaque3;

    int rom_mode = 0;

    always #5 vga_clk = ~vga_clk;

    tile_bg_renderer #(.ROM_LAT(1)) dut1 (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .rom_address(rom_address1), .rom_q(rom_q1), .pal_we(pal_we),
        .pal_idx(pal_idx), .pal_data(pal_data), .fade_go(fade_go),
        .fade_dir(fade_dir), .red(red1), .green(green1), .blue(blue1),
        .opaque(opaque1)
    );

    tile_bg_renderer #(.ROM_LAT(3)) dut3 (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .rom_address(rom_address3), .rom_q(rom_q3), .pal_we(pal_we),
        .pal_idx(pal_idx), .pal_data(pal_data), .fade_go(fade_go),
        .fade_dir(fade_dir), .red(red3), .green(green3), .blue(blue3),
        .opaque(opaque3)
    );

    // ROM content as a function of texel address
    function automatic logic [3:0] rom_val(input logic [11:0] a);
        case (rom_mode)
            0:       return 4'd5;
            1:       return 4'd0;
            default: return a[3:0] ^ a[9:6];
        endcase
    endfunction

    // External ROMs with 1 and 3 cycles of read latency
    logic [11:0] a3_d1 = '0, a3_d2 = '0;
    always @(posedge vga_clk) begin
        rom_q1 <= rom_val(rom_address1);
        a3_d1  <= rom_address3;
        a3_d2  <= a3_d1;
        rom_q3 <= rom_val(a3_d2);
    end

    // ------------------------------------------------------------------
    // Behavioural model: per-cycle sample history + palette/scroll/level
    // ------------------------------------------------------------------
    logic        h_blank [c_HIST];
    logic [3:0]  h_idx   [c_HIST];
    logic [11:0] m_pal   [16];
    int          m_sx, m_sy, m_level;
    int          cyc_n    = 0;
    int          last_rst = -1000;
    logic [11:0] e_addr;
    logic [12:0] e1, e3;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {opaque, R, G, B} registered at edge n by a pipe of depth lat
    function automatic logic [12:0] exp_out(input int n, input int lat);
        int          s;
        logic [11:0] c;
        int          r, g, b;
        s = n - lat;
        if (s < 0 || s <= last_rst) return 13'd0;
        if (!h_blank[s]) return 13'd0;
        c = m_pal[h_idx[s]];
        r = (int'(c[11:8]) * m_level) / 16;
        g = (int'(c[7:4])  * m_level) / 16;
        b = (int'(c[3:0])  * m_level) / 16;
        return {h_idx[s] != 4'd0, 4'(r), 4'(g), 4'(b)};
    endfunction

    // Advances the model for the inputs about to be sampled at the next edge
    task automatic model_step();
        logic [12:0] o1, o3;
        int          tx, ty;
        o1 = exp_out(cyc_n, 3);
        o3 = exp_out(cyc_n, 5);
        if (Reset) begin
            last_rst = cyc_n;
            e_addr   = 12'd0;
            e1       = 13'd0;
            e3       = 13'd0;
            m_sx     = 0;
            m_sy     = 0;
            m_level  = 16;
            for (int i = 0; i < 16; i++) m_pal[i] = 12'd0;
            h_blank[cyc_n] = 1'b0;
            h_idx[cyc_n]   = 4'd0;
        end else begin
            e1 = o1;
            e3 = o3;
            if (pal_we) m_pal[pal_idx] = pal_data;
            if (DrawX == 10'd0 && DrawY == 10'd0) begin
                m_sx = int'(scroll_x);
                m_sy = int'(scroll_y);
`ifdef BG_FADE_EN
                if (fade_go) begin
                    if (fade_dir && m_level < 16) m_level = m_level + 1;
                    else if (!fade_dir && m_level > 0) m_level = m_level - 1;
                end
`endif
            end
            tx = (int'(DrawX) / 8 + m_sx) % 64;
            ty = (int'(DrawY) / 8 + m_sy) % 64;
            e_addr = 12'(ty * 64 + tx);
            h_blank[cyc_n] = blank;
            h_idx[cyc_n]   = rom_val(e_addr);
        end
        cyc_n++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // One pixel clock: drive, advance model, clock, compare at the negedge
    task automatic cyc(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        model_step();
        @(posedge vga_clk);
        @(negedge vga_clk);
        check("addr_lat1", 32'(rom_address1), 32'(e_addr));
        check("addr_lat3", 32'(rom_address3), 32'(e_addr));
        check("rgb_lat1", 32'({red1, green1, blue1}), 32'(e1[11:0]));
        check("opq_lat1", 32'(opaque1), 32'(e1[12]));
        check("rgb_lat3", 32'({red3, green3, blue3}), 32'(e3[11:0]));
        check("opq_lat3", 32'(opaque3), 32'(e3[12]));
    endtask

    task automatic run(input int x, input int y, input logic b, input int n);
        for (int i = 0; i < n; i++) cyc(x, y, b);
    endtask

    task automatic pal_write(input logic [3:0] i, input logic [11:0] d);
        pal_we = 1'b1; pal_idx = i; pal_data = d;
        cyc(300, 300, 1'b0);
        pal_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    int rows [6] = '{0, 7, 8, 63, 300, 479};

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
        scroll_x = '0; scroll_y = '0; pal_we = 1'b0; pal_idx = '0;
        pal_data = '0; fade_go = 1'b0; fade_dir = 1'b0;
        @(negedge vga_clk);

        // Reset state
        run(5, 5, 1'b1, 3);
        check("rst_addr", 32'(rom_address1), 32'd0);
        check("rst_rgb", 32'({red1, green1, blue1}), 32'd0);
        check("rst_opq", 32'(opaque1), 32'd0);
        Reset = 1'b0;

        // Basic lookup and address generation
        pal_write(4'd5, 12'hF80);
        cyc(0, 0, 1'b1);
        check("lit_addr00", 32'(rom_address1), 32'd0);
        cyc(17, 9, 1'b1);
        check("lit_addr17_9", 32'(rom_address1), 32'd66);
        run(17, 9, 1'b1, 2);
        check("lit_rgb_f80_l1", 32'({red1, green1, blue1}), 32'hF80);
        check("lit_opq_l1", 32'(opaque1), 32'd1);
        check("lit_rgb_l3_early", 32'({red3, green3, blue3}), 32'h000);
        run(17, 9, 1'b1, 2);
        check("lit_rgb_f80_l3", 32'({red3, green3, blue3}), 32'hF80);

        // Scroll wrap and frame-start latching
        scroll_x = 6'd63;
        cyc(0, 0, 1'b1);
        check("lit_scroll63", 32'(rom_address1), 32'd63);
        cyc(8, 0, 1'b1);
        check("lit_wrap", 32'(rom_address1), 32'd0);
        scroll_x = 6'd10;
        cyc(16, 0, 1'b1);
        check("lit_midframe", 32'(rom_address1), 32'd1);
        cyc(0, 0, 1'b1);
        check("lit_newframe", 32'(rom_address1), 32'd10);
        scroll_x = 6'd0;
        cyc(0, 0, 1'b1);

        // Transparent index and blank alignment
        run(300, 300, 1'b0, 7);
        rom_mode = 1;
        pal_write(4'd0, 12'h123);
        cyc(40, 0, 1'b1);
        cyc(48, 0, 1'b0);
        run(56, 0, 1'b0, 2);
        check("lit_trans_rgb", 32'({red1, green1, blue1}), 32'h123);
        check("lit_trans_opq", 32'(opaque1), 32'd0);
        cyc(72, 0, 1'b0);
        check("lit_blank_rgb", 32'({red1, green1, blue1}), 32'h000);
        cyc(80, 0, 1'b0);
        check("lit_trans_rgb_l3", 32'({red3, green3, blue3}), 32'h123);
        cyc(88, 0, 1'b0);
        check("lit_blank_rgb_l3", 32'({red3, green3, blue3}), 32'h000);
        run(300, 300, 1'b0, 7);
        rom_mode = 0;

        // Palette write coinciding with a registered lookup
        cyc(0, 8, 1'b1);
        cyc(8, 8, 1'b1);
        cyc(16, 8, 1'b1);
        pal_we = 1'b1; pal_idx = 4'd5; pal_data = 12'h00F;
        cyc(24, 8, 1'b1);
        pal_we = 1'b0;
        check("lit_wr_old", 32'({red1, green1, blue1}), 32'hF80);
        cyc(32, 8, 1'b1);
        check("lit_wr_new", 32'({red1, green1, blue1}), 32'h00F);
        run(40, 8, 1'b1, 4);

        // Reset mid-frame; scroll stays 0 until the next frame start
        scroll_x = 6'd5;
        cyc(24, 0, 1'b1);
        Reset = 1'b1;
        cyc(32, 0, 1'b1);
        Reset = 1'b0;
        cyc(32, 0, 1'b1);
        check("lit_rst_addr", 32'(rom_address1), 32'd4);
        run(40, 0, 1'b1, 6);
        scroll_x = 6'd0;

        // Varied pattern: distinct palette, address-dependent ROM
        run(300, 300, 1'b0, 7);
        rom_mode = 2;
        for (int i = 0; i < 16; i++)
            pal_write(4'(i), {4'(i), 4'(15 - i), 4'(i) ^ 4'h5});
        scroll_x = 6'd37; scroll_y = 6'd50;
        cyc(0, 0, 1'b1);
        scroll_x = 6'd3; scroll_y = 6'd9;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 18; c++) begin
                if (c == 9) begin
                    pal_we = 1'b1; pal_idx = 4'(r + c); pal_data = 12'(r * 273 + c);
                end
                cyc(c * 37, rows[r], (c * 37) < 600);
                pal_we = 1'b0;
            end
        end
        cyc(0, 0, 1'b1);
        for (int c = 0; c < 12; c++) cyc(c * 53, 200 + c, 1'b1);
        scroll_x = 6'd0; scroll_y = 6'd0;
        run(300, 300, 1'b0, 7);
        rom_mode = 0;

`ifdef BG_FADE_EN
        pal_write(4'd5, 12'hFFF);
        fade_dir = 1'b0;
        for (int f = 0; f < 8; f++) begin
            fade_go = 1'b1; cyc(0, 0, 1'b1);
            fade_go = 1'b0; cyc(8, 0, 1'b1);
        end
        run(16, 0, 1'b1, 6);
        check("lit_fade8", 32'({red1, green1, blue1}), 32'h777);
        for (int f = 0; f < 8; f++) begin
            fade_go = 1'b1; cyc(0, 0, 1'b1);
            fade_go = 1'b0; cyc(8, 0, 1'b1);
        end
        run(16, 0, 1'b1, 6);
        check("lit_fade0", 32'({red1, green1, blue1}), 32'h000);
        check("lit_fade0_opq", 32'(opaque1), 32'd1);
        fade_go = 1'b1; cyc(0, 0, 1'b1);
        fade_go = 1'b0;
        run(16, 0, 1'b1, 6);
        check("lit_fade_sat0", 32'({red1, green1, blue1}), 32'h000);
        fade_dir = 1'b1;
        for (int f = 0; f < 17; f++) begin
            fade_go = 1'b1; cyc(0, 0, 1'b1);
            fade_go = 1'b0; cyc(8, 0, 1'b1);
        end
        run(16, 0, 1'b1, 6);
        check("lit_fade_sat16", 32'({red1, green1, blue1}), 32'hFFF);
`endif

        run(300, 300, 1'b0, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
